// File: rtl/yt3817_bin_thresh_if.sv
// Pixel bus into the binarizer and binarized pixel bus out of it.
//   de, red/green/blue_8bits, H_Addr, V_Addr : camera pixel stream (source -> binarizer)
//   bin_valid, bin_data, H_Addr_o, V_Addr_o   : binarized stream (binarizer -> BPPU)
// master = pixel source / bin consumer, slave = binarizer.
interface yt3817_bin_thresh_if;
  logic        de;
  logic [7:0]  red_8bits;
  logic [7:0]  green_8bits;
  logic [7:0]  blue_8bits;
  logic [11:0] H_Addr;
  logic [11:0] V_Addr;
  logic        bin_valid;
  logic        bin_data;
  logic [11:0] H_Addr_o;
  logic [11:0] V_Addr_o;

  modport master (
    output de, red_8bits, green_8bits, blue_8bits, H_Addr, V_Addr,
    input  bin_valid, bin_data, H_Addr_o, V_Addr_o
  );

  modport slave (
    input  de, red_8bits, green_8bits, blue_8bits, H_Addr, V_Addr,
    output bin_valid, bin_data, H_Addr_o, V_Addr_o
  );
endinterface

// File: rtl/yt3817_bin_thresh.sv
// RGB -> luma -> 1-bit binarizer feeding the BPPU digit-crossing counter.
// Fixed 3-stage pipeline (multiply / sum / compare), no stalls.
// The threshold adapts once per frame to the mid-point of that frame's luma
// min/max (when contrast is sufficient) and can be overridden manually.
// Ports:
//   clk, srst     : pixel clock, synchronous active-high reset
//   pix           : pixel in / binarized pixel out bus (slave side)
//   th_manual_en  : select th_manual instead of the adaptive threshold
//   th_manual     : manual threshold
//   threshold     : adaptive threshold currently in force
//   frame_done    : 1-cycle pulse alongside the last active pixel at the output
module yt3817_bin_thresh #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 480,
  parameter int DEFAULT_TH   = 128,
  parameter int MIN_CONTRAST = 32,
  parameter int INK_DARK     = 1
) (
  input  logic                      clk,
  input  logic                      srst,
  yt3817_bin_thresh_if.slave        pix,
  input  logic                      th_manual_en,
  input  logic [7:0]                th_manual,
  output logic [7:0]                threshold,
  output logic                      frame_done
);
  localparam int          STAGES = 3;
  localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);
  localparam logic [7:0]  MIN_C  = 8'(MIN_CONTRAST);
  localparam logic [7:0]  TH0    = 8'(DEFAULT_TH);

  // de/H/V travel alongside the data; index = stage number
  logic [STAGES:1]       vld_pipe;
  logic [STAGES:1][11:0] h_pipe;
  logic [STAGES:1][11:0] v_pipe;

  logic [15:0] p_r, p_g, p_b;   // S1 products
  logic [7:0]  luma;            // S2
  logic        bin_r;           // S3
  logic [7:0]  min_acc, max_acc;

  logic [17:0] sum;
  logic        in_act, last_px, dark;
  logic [7:0]  th_eff, nxt_min, nxt_max, contrast, th_new;
  logic [8:0]  th_sum;

  assign sum = 18'(p_r) + 18'(p_g) + 18'(p_b);

  // Stats are taken from the S2 pixel; the frame-end pixel is always in range.
  assign in_act  = vld_pipe[2] && (h_pipe[2] < H_LIM) && (v_pipe[2] < V_LIM);
  assign last_px = vld_pipe[2] && (h_pipe[2] == H_LAST) && (v_pipe[2] == V_LAST);

  // Threshold is sampled before this edge's update, so the last pixel of a
  // frame still sees the old value.
  assign th_eff = th_manual_en ? th_manual : threshold;
  assign dark   = luma < th_eff;

  always_comb begin
    nxt_min = min_acc;
    nxt_max = max_acc;
    if (in_act) begin
      if (luma < min_acc) nxt_min = luma;
      if (luma > max_acc) nxt_max = luma;
    end
  end

  // nxt_max >= nxt_min whenever this is used (last pixel folded in)
  assign contrast = nxt_max - nxt_min;
  assign th_sum   = 9'(nxt_min) + 9'(nxt_max);
  assign th_new   = 8'(th_sum >> 1);

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_pipe   <= '0;
      h_pipe     <= '0;
      v_pipe     <= '0;
      p_r        <= '0;
      p_g        <= '0;
      p_b        <= '0;
      luma       <= '0;
      bin_r      <= 1'b0;
      frame_done <= 1'b0;
      threshold  <= TH0;
      min_acc    <= 8'hFF;
      max_acc    <= 8'h00;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix.de};
      h_pipe   <= {h_pipe[STAGES-1:1], pix.H_Addr};
      v_pipe   <= {v_pipe[STAGES-1:1], pix.V_Addr};
      // S1: BT.601-ish weights scaled by 256 (77+150+29 = 256)
      p_r      <= 16'(pix.red_8bits)   * 16'd77;
      p_g      <= 16'(pix.green_8bits) * 16'd150;
      p_b      <= 16'(pix.blue_8bits)  * 16'd29;
      // S2
      luma     <= 8'(sum >> 8);
      // S3: invalid slots carry bin_data = 0
      bin_r    <= vld_pipe[2] & ((INK_DARK != 0) ? dark : ~dark);
      frame_done <= last_px;
      if (last_px) begin
        if (contrast >= MIN_C) threshold <= th_new;
        min_acc <= 8'hFF;
        max_acc <= 8'h00;
      end else begin
        min_acc <= nxt_min;
        max_acc <= nxt_max;
      end
    end
  end

  assign pix.bin_valid = vld_pipe[STAGES];
  assign pix.bin_data  = bin_r;
  assign pix.H_Addr_o  = h_pipe[STAGES];
  assign pix.V_Addr_o  = v_pipe[STAGES];
endmodule

// File: tb/tb_yt3817_bin_thresh.sv
// Scoreboard bench for yt3817_bin_thresh on a reduced 40x24 frame.
// Stimulus pushes the expected output of every de=1 pixel; a negedge monitor
// pops and compares whenever bin_valid is seen.
module tb_yt3817_bin_thresh;
  localparam int H_ACT = 40;
  localparam int V_ACT = 24;

  logic       clk = 1'b0;
  logic       srst;
  logic       th_manual_en;
  logic [7:0] th_manual;
  logic [7:0] threshold;
  logic       frame_done;

  yt3817_bin_thresh_if pix ();

  yt3817_bin_thresh #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .DEFAULT_TH(128),
    .MIN_CONTRAST(32), .INK_DARK(1)
  ) dut (
    .clk(clk), .srst(srst), .pix(pix),
    .th_manual_en(th_manual_en), .th_manual(th_manual),
    .threshold(threshold), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bin;
    logic [11:0] h;
    logic [11:0] v;
    logic        fd;
    int          stamp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   fd_cnt = 0;
  int   ones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (pix.bin_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("bin_data",   int'(pix.bin_data), int'(mon_e.bin));
        chk("H_Addr_o",   int'(pix.H_Addr_o), int'(mon_e.h));
        chk("V_Addr_o",   int'(pix.V_Addr_o), int'(mon_e.v));
        chk("frame_done", int'(frame_done),   int'(mon_e.fd));
        chk("latency",    cyc,                mon_e.stamp + 3);
        if (pix.bin_data === 1'b1 && pix.H_Addr_o < 12'(H_ACT)) ones++;
      end
    end else if (frame_done === 1'b1) chk("stray_frame_done", 1, 0);
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic drive(input logic de, input int l, input int h, input int v,
                       input int th_exp);
    @(posedge clk); #1;
    pix.de          = de;
    pix.red_8bits   = 8'(l);
    pix.green_8bits = 8'(l);
    pix.blue_8bits  = 8'(l);
    pix.H_Addr      = 12'(h);
    pix.V_Addr      = 12'(v);
    // R=G=B=l gives luma l exactly; INK_DARK=1 -> ink when luma < threshold
    if (de) q.push_back('{bin: (l < th_exp), h: 12'(h), v: 12'(v),
                          fd: (h == H_ACT-1 && v == V_ACT-1), stamp: cyc});
  endtask

  function automatic int lum(input int kind, input int h, input int v);
    case (kind)
      0: return (h == 3 && v == 3) ? 120 : 100;                          // low contrast
      1: return (h >= 10 && h <= 19 && v >= 5 && v <= 14) ? 0 : 255;     // bar on white
      2: return (h == 0 && v == 0) ? 40 : (h == 1 && v == 0) ? 200 : 60; // manual test
      default: return 200;                                               // uniform 200
    endcase
  endfunction

  // Each line: active pixels, one de=1 pixel past H_ACTIVE (black, must not
  // reach stats), one de=0 black pixel inside the area (must not reach stats).
  task automatic frame(input int kind, input int th_exp, input int stop_v);
    for (int v = 0; v < V_ACT; v++) begin
      if (v == stop_v) return;
      for (int h = 0; h < H_ACT; h++) drive(1'b1, lum(kind, h, v), h, v, th_exp);
      drive(1'b1, 0, H_ACT, v, th_exp);
      drive(1'b0, 0, 0, v, th_exp);
    end
  endtask

  task automatic drain(input string nm);
    drive(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) drive(1'b0, 0, 0, 0, 0);
    chk(nm, q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    srst   = 1'b1;
    pix.de = 1'b0;
    @(posedge clk); #1;
    q.delete();   // anything in flight is wiped by the reset edge
    for (int i = 1; i < cycles; i++) begin @(posedge clk); #1; end
    srst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  int fd0;

  initial begin
    srst = 1'b1; th_manual_en = 1'b0; th_manual = 8'd0;
    pix.de = 1'b0; pix.red_8bits = 0; pix.green_8bits = 0; pix.blue_8bits = 0;
    pix.H_Addr = 0; pix.V_Addr = 0;

    // 1 Reset held 2 cycles
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_bin_valid",  int'(pix.bin_valid), 0);
    chk("rst_bin_data",   int'(pix.bin_data),  0);
    chk("rst_H_o",        int'(pix.H_Addr_o),  0);
    chk("rst_V_o",        int'(pix.V_Addr_o),  0);
    chk("rst_frame_done", int'(frame_done),    0);
    chk("rst_threshold",  int'(threshold),     128);
    @(posedge clk); #1; srst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_bin_valid", int'(pix.bin_valid), 0);
    end

    // 2 Latency / luma
    drive(1'b1, 200, 5, 7, 128);
    drive(1'b1, 10, 6, 7, 128);
    drain("drain_t2");
    do_reset(2);

    // 4 Low contrast: threshold stays, everything is ink
    fd0 = fd_cnt;
    frame(0, 128, -1);
    drain("drain_t4");
    chk("t4_threshold", int'(threshold), 128);
    chk("t4_fd_pulses", fd_cnt - fd0, 1);

    // 3 Adaptive: bar frame -> 127, then bar frame binarized against 127
    fd0 = fd_cnt;
    frame(1, 128, -1);
    drain("drain_t3a");
    chk("t3_threshold", int'(threshold), 127);
    chk("t3_fd_pulses", fd_cnt - fd0, 1);
    ones = 0;
    frame(1, 127, -1);
    drain("drain_t3b");
    chk("t3_bar_ones", ones, 100);
    chk("t3_threshold2", int'(threshold), 127);

    // 5 Manual override 50; adaptive keeps tracking (min 40, max 200 -> 120)
    th_manual_en = 1'b1; th_manual = 8'd50;
    frame(2, 50, -1);
    drain("drain_t5");
    chk("t5_threshold", int'(threshold), 120);
    th_manual_en = 1'b0;

    // 6 Mid-frame reset, then a uniform frame
    fd0 = fd_cnt;
    frame(1, 120, 12);
    do_reset(1);
    chk("t6_rst_threshold", int'(threshold), 128);
    frame(3, 128, -1);
    drain("drain_t6");
    chk("t6_threshold", int'(threshold), 128);
    chk("t6_fd_pulses", fd_cnt - fd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
